mult4u_dual_sched: RTL

MULT4U_DUAL_SCHED -- requirements
Module: mult4u_dual_sched

---
 rtl/mult4u_pkg.sv | 15 +
 rtl/mult4u_core.sv | 13 +
 rtl/mult4u_dual_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mult4u_pkg.sv
// rtl/mult4u_pkg.sv - shared widths and FSM state type for the dual-pass multiplier scheduler
package mult4u_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mult4u_core.sv
// rtl/mult4u_core.sv - combinational 4x4 unsigned multiplier core
module mult4u_core
    import mult4u_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] prod_o
);

    // Operands widened first so the full 8-bit product is kept.
    assign prod_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/mult4u_dual_sched.sv
// rtl/mult4u_dual_sched.sv - two-requester round-robin scheduler around one multiplier with optional swapped-operand self-check
module mult4u_dual_sched
    import mult4u_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_prod,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic                id_q, id_d;
    logic [PROD_W-1:0]   p1_q, p1_d;
    logic [PROD_W-1:0]   rsp_prod_q, rsp_prod_d;
    logic                rsp_id_q, rsp_id_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic                grant_any, grant_id, accept;
    logic [OP_W-1:0]     core_a, core_b;
    logic [PROD_W-1:0]   core_prod;

    // Round-robin grant: pointer breaks ties, a lone requester always wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    end

    assign req0_ready = (state_q == IDLE) && !rst && grant_any && !grant_id;
    assign req1_ready = (state_q == IDLE) && !rst && grant_any &&  grant_id;
    assign accept     = req0_ready | req1_ready;

    // The second pass feeds the same core with swapped operands.
    assign core_a = (state_q == PASS2) ? b_q : a_q;
    assign core_b = (state_q == PASS2) ? a_q : b_q;

    mult4u_core u_core (
        .a_i    (core_a),
        .b_i    (core_b),
        .prod_o (core_prod)
    );

    // Next-state and datapath update; response registers only change on entry to HOLD.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        p1_d       = p1_q;
        rsp_prod_d = rsp_prod_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    ptr_d   = ~grant_id;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                p1_d = core_prod;
                if (CHECK_EN) begin
                    state_d = PASS2;
                end else begin
                    rsp_prod_d = core_prod;
                    rsp_id_d   = id_q;
                    rsp_err_d  = 1'b0;
                    state_d    = HOLD;
                end
            end
            PASS2: begin
                rsp_prod_d = p1_q;
                rsp_id_d   = id_q;
                rsp_err_d  = (core_prod != p1_q);
                if ((core_prod != p1_q) && (err_cnt_q != {ERR_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset that also drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            p1_q       <= '0;
            rsp_prod_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            p1_q       <= p1_d;
            rsp_prod_q <= rsp_prod_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_prod  = rsp_prod_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule
